gray_seq_ctrl: RTL
==================

// Module: gray_seq_ctrl
// PURPOSE
//  Sequencer for the SR-flip-flop Gray-code mod counter. Owns the Gray state register and the
//  command FSM (run/stop/single-step/load). Emits per-bit S/R excitation for every state change.
//  Sits between the control bus (valid/ready commands) and the SR-FF counter datapath.
// PARAMETERS
//  WIDTH     4        counter width in bits
//  TC_RST    4'b1000  reset value of the internal terminal register; Gray 1000 = binary 15
//  ONE_SHOT  0        1: RUN stops in DONE after one wrap; 0: RUN counts continuously
// PORTS
//  clk        in   1      clock, rising edge
//  c          in   1      clear; asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
//  cmd_op     in   2      00 STOP, 01 RUN, 10 STEP, 11 LOAD
//  cmd_data   in   WIDTH  LOAD value (Gray)
//  dir        in   1      0 up, 1 down; sampled on every advance cycle
//  tc_val     in   WIDTH  terminal value (Gray); used when tc_we=1, else internal reg holds
//  tc_we      in   1      write tc_val into internal terminal register (takes effect next cycle)
//  q          out  WIDTH  current Gray state
//  s, r       out  WIDTH  SR excitation for the transition at the next edge
//  tc         out  1      one-cycle wrap pulse
//  busy       out  1      state is RUN or STEP
//  fsm        out  2      00 IDLE, 01 RUN, 10 STEP, 11 DONE
// BEHAVIOUR
//  Reset (c=1, async): q=0, fsm=IDLE, tc=0, s=r=0, busy=0, term=TC_RST. cmd_ready=1 once c drops.
//  adv = (fsm==RUN | fsm==STEP) & ~load_acc, where load_acc = cmd_valid & cmd_ready & op==LOAD.
//  Successor, up:   q==term -> 0; else bin2gray(gray2bin(q)+1) mod 2^WIDTH.
//  Successor, down: q==0 -> term; else bin2gray(gray2bin(q)-1).
//  - Values above term count naturally: 2^WIDTH-1 wraps to 0 up with no tc.
//  - Gray successors differ from q in exactly one bit.
//  nxt is successor when adv; cmd_data when load_acc; else q. q <= nxt each edge.
//  s = nxt & ~q; r = ~nxt & q (combinational). s & r == 0 always; both all-zero when q holds.
//  tc registered: 1 in the cycle after an adv from term (up) or from 0 (down),
//  i.e. coincident with the wrapped q. Never set by LOAD.
//  Commands take effect at the next edge. The current cycle's adv still occurs.
//  - STOP: RUN/DONE -> IDLE; no-op in IDLE.
//  - RUN: IDLE/DONE -> RUN; no-op in RUN.
//  - STEP: IDLE/DONE -> STEP; accepted and ignored in RUN.
//  - LOAD: any state -> IDLE; q <= cmd_data; suppresses adv that cycle.
//  STEP lasts exactly one cycle (one adv), then -> IDLE. cmd_ready = (fsm != STEP).
//  ONE_SHOT=1: adv causing tc moves RUN -> DONE (q already wrapped). STEP never enters DONE.
//  ONE_SHOT=0: RUN persists across wraps.
//  fsm encoding 11 (DONE) is unreachable when ONE_SHOT=0. Illegal fsm states recover to IDLE.
//  term changes mid-RUN are honoured from the following cycle.
//  Any cycle after q passes term going up (q > term) is unaffected.
//  Reset mid-operation: immediate return to reset values; pending command dropped.
// TESTING
//  1) Reset, RUN, dir=0, term=1000, ONE_SHOT=0:
//     q = 0000,0001,0011,0010,0110,...,1000,0000. tc=1 only with second 0000.
//     Exactly one bit changes per step.
//  2) Every cycle of test 1: s&r==0. s|r equals q^next_q. s=r=0 while IDLE.
//  3) LOAD 0101 during RUN: next cycle q=0101, fsm=IDLE, tc=0.
//     s=0101&~q_old and r=~0101&q_old in the accept cycle.
//  4) In IDLE with q=0000: STEP -> q=0001, fsm IDLE after one cycle.
//     cmd_ready=0 during STEP. dir=1 STEP from 0000 -> q=term, tc=1.
//  5) ONE_SHOT=1, term=0011 (bin 2), RUN from 0: q 0001,0011,0000 then fsm=DONE, q holds.
//     RUN restarts counting.
//  6) Assert c mid-RUN, between edges: q,s,r,tc,busy=0 immediately.
//     After release, STOP-only traffic keeps q=0000.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - Gray-code mod counter sequencer with SR excitation outputs
module gray_seq_ctrl #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TC_RST   = 4'b1000,
    parameter bit               ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             c,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             dir,
    input  logic [WIDTH-1:0] tc_val,
    input  logic             tc_we,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             tc,
    output logic             busy,
    output logic [1:0]       fsm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_e           fsm_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] succ;
    logic             tc_q;
    logic             tc_d;
    logic             cmd_acc;
    logic             load_acc;
    logic             adv;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // cmd_ready is held low while clear is asserted so nothing is accepted in reset
    assign cmd_ready = ~c & (fsm_q != ST_STEP);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign load_acc  = cmd_acc & (cmd_op == OP_LOAD);
    assign adv       = ((fsm_q == ST_RUN) | (fsm_q == ST_STEP)) & ~load_acc;

    always_comb begin
        succ = '0;
        if (!dir) begin
            succ = (q_q == term_q) ? '0 : bin2gray(gray2bin(q_q) + 1'b1);
        end else begin
            succ = (q_q == '0) ? term_q : bin2gray(gray2bin(q_q) - 1'b1);
        end
    end

    always_comb begin
        q_d = q_q;
        if (adv) begin
            q_d = succ;
        end else if (load_acc) begin
            q_d = cmd_data;
        end
    end

    assign tc_d = adv & (dir ? (q_q == '0) : (q_q == term_q));

    assign s    = q_d & ~q_q;
    assign r    = ~q_d & q_q;
    assign q    = q_q;
    assign tc   = tc_q;
    assign fsm  = fsm_q;
    assign busy = (fsm_q == ST_RUN) | (fsm_q == ST_STEP);

    always_ff @(posedge clk or posedge c) begin
        if (c) begin
            fsm_q  <= ST_IDLE;
            q_q    <= '0;
            tc_q   <= 1'b0;
            term_q <= TC_RST;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
            if (tc_we) begin
                term_q <= tc_val;
            end
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    if (cmd_acc) begin
                        case (cmd_op)
                            OP_RUN:  fsm_q <= ST_RUN;
                            OP_STEP: fsm_q <= ST_STEP;
                            default: fsm_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    // STOP/LOAD win over a simultaneous one-shot wrap
                    if (cmd_acc && (cmd_op == OP_STOP || cmd_op == OP_LOAD)) begin
                        fsm_q <= ST_IDLE;
                    end else if (ONE_SHOT && tc_d) begin
                        fsm_q <= ST_DONE;
                    end
                end
                ST_STEP: fsm_q <= ST_IDLE;
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule
